// File: rtl/cnt_ex_pkg.sv
// Shared types and constants for the counter exerciser.
package cnt_ex_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;
  localparam int unsigned RUN_LEN_W     = 8;
  localparam int unsigned ERR_CNT_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COUNT,
    ST_HOLD,
    ST_FINAL
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_LOAD = 2'b01,
    ERR_INC  = 2'b10,
    ERR_HOLD = 2'b11
  } err_code_e;

  // Error type attributed to a cycle driven from the given state; NONE for undriven states.
  function automatic err_code_e phase_code(input state_e st);
    case (st)
      ST_LOAD:  phase_code = ERR_LOAD;
      ST_COUNT: phase_code = ERR_INC;
      ST_HOLD:  phase_code = ERR_HOLD;
      default:  phase_code = ERR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cnt_ex_model.sv
// Expected-value model of the counter under test and the one-cycle-late compare of cout.
module cnt_ex_model
  import cnt_ex_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  err_code_e        drv_phase,
  input  logic             drv_load,
  input  logic             drv_enable,
  input  logic [WIDTH-1:0] drv_data,
  input  logic [WIDTH-1:0] cout,
  output logic             mismatch_c,
  output err_code_e        chk_phase
);

  logic [WIDTH-1:0] exp_q, exp_d;
  logic             chk_q, chk_d;
  err_code_e        phase_q, phase_d;
  logic [WIDTH-1:0] base;

  assign chk_phase = phase_q;

  // After a mismatch the model re-aligns to the observed count, so each faulty step is reported once.
  always_comb begin
    mismatch_c = chk_q && (cout != exp_q);
    base       = mismatch_c ? cout : exp_q;
    exp_d      = base;
    if (drv_load) begin
      exp_d = drv_data;
    end else if (drv_enable) begin
      exp_d = base + WIDTH'(1);
    end
    chk_d   = (drv_phase != ERR_NONE);
    phase_d = drv_phase;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q   <= '0;
      chk_q   <= 1'b0;
      phase_q <= ERR_NONE;
    end else begin
      exp_q   <= exp_d;
      chk_q   <= chk_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/counter_exerciser.sv
// Drives a load/count/hold sequence into an external counter and scores its returned count.
// HOLD_CYCLES must be at least 1.
module counter_exerciser #(
  parameter int unsigned WIDTH       = cnt_ex_pkg::WIDTH_DEFAULT,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] cfg_load_value,
  input  logic [7:0]       cfg_run_len,
  input  logic [WIDTH-1:0] cout,
  output logic             load,
  output logic             enable,
  output logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [1:0]       err_code
);

  import cnt_ex_pkg::*;

  localparam int unsigned CNT_W = (HOLD_CYCLES > 256) ? $clog2(HOLD_CYCLES) : 8;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     load_val_q, load_val_d;
  logic [RUN_LEN_W-1:0] run_len_q, run_len_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 load_q, load_d;
  logic                 enable_q, enable_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  err_code_e            err_code_q, err_code_d;
  logic                 start_acc;
  logic                 mismatch_c;
  err_code_e            chk_phase;

  assign load      = load_q;
  assign enable    = enable_q;
  assign data      = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign err_code  = err_code_q;

  cnt_ex_model #(
    .WIDTH (WIDTH)
  ) u_model (
    .clk        (clk),
    .reset      (reset),
    .drv_phase  (phase_code(state_q)),
    .drv_load   (load_q),
    .drv_enable (enable_q),
    .drv_data   (data_q),
    .cout       (cout),
    .mismatch_c (mismatch_c),
    .chk_phase  (chk_phase)
  );

  // Sequencer: next state, phase length counter and captured configuration.
  always_comb begin
    state_d    = state_q;
    load_val_d = load_val_q;
    run_len_d  = run_len_q;
    cnt_d      = cnt_q;
    start_acc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          load_val_d = cfg_load_value;
          run_len_d  = cfg_run_len;
          start_acc  = 1'b1;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = (run_len_q == '0) ? ST_HOLD : ST_COUNT;
      end
      ST_COUNT: begin
        if (cnt_q == CNT_W'(run_len_q) - CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_FINAL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FINAL: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Results: cleared on an accepted start, scored per mismatch; pass folds in the check landing in FINAL.
  always_comb begin
    pass_d      = pass_q;
    err_count_d = err_count_q;
    err_code_d  = err_code_q;
    if (start_acc) begin
      pass_d      = 1'b0;
      err_count_d = '0;
      err_code_d  = ERR_NONE;
    end else if (mismatch_c) begin
      if (err_count_q != '1) begin
        err_count_d = err_count_q + ERR_CNT_W'(1);
      end
      if (err_code_q == ERR_NONE) begin
        err_code_d = chk_phase;
      end
    end
    if (state_q == ST_FINAL) begin
      pass_d = (err_count_d == '0);
    end
  end

  // Outputs are decoded from the next state so the registered values line up with state_q.
  always_comb begin
    load_d   = (state_d == ST_LOAD);
    enable_d = (state_d == ST_LOAD) || (state_d == ST_COUNT);
    data_d   = (state_d == ST_LOAD) ? load_val_d : '0;
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_FINAL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      load_val_q  <= '0;
      run_len_q   <= '0;
      cnt_q       <= '0;
      load_q      <= 1'b0;
      enable_q    <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      load_val_q  <= load_val_d;
      run_len_q   <= run_len_d;
      cnt_q       <= cnt_d;
      load_q      <= load_d;
      enable_q    <= enable_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      err_code_q  <= err_code_d;
    end
  end

endmodule
